// File: rtl/bitserial_func_ctrl.sv
// Bit-serial controller for an external 1-bit function unit.
// An accepted request streams operand bits LSB first to the unit, one bit per cycle. The
// returned bits are assembled into a word that is published on result when the last bit lands.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - operation request, only looked at in IDLE
//   op      - 3-bit function code
//   opa     - operand A (WIDTH bits)
//   opb     - operand B (WIDTH bits)
//   busy    - high while bits are streaming (RUN)
//   done    - one-cycle completion pulse (DONE)
//   result  - last completed result, held until the next completion
//   fu_a    - A bit to the function unit
//   fu_b    - B bit to the function unit
//   fu_sel  - function select to the function unit
//   fu_out  - combinational function-unit output for the current fu_a/fu_b/fu_sel
module bitserial_func_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             fu_a,
    output logic             fu_b,
    output logic [2:0]       fu_sel,
    input  logic             fu_out
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    op_d    = op;
                    a_d     = opa;
                    b_d     = opb;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                // The unit's answer for the bit on the wires lands in the MSB; after WIDTH
                // shifts the first bit has walked down to bit 0.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fu_out, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    state_d  = StDone;
                    result_d = res_d;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    // Function-unit drive is forced quiet outside RUN.
    assign fu_a   = busy_q & a_q[0];
    assign fu_b   = busy_q & b_q[0];
    assign fu_sel = busy_q ? op_q : 3'b000;

endmodule

// File: tb/tb_bitserial_func_ctrl.sv
module tb_bitserial_func_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             fu_a;
    logic             fu_b;
    logic [2:0]       fu_sel;
    logic             fu_out;

    int checks;
    int errors;
    logic [WIDTH-1:0] last_result;

    bitserial_func_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .fu_a   (fu_a),
        .fu_b   (fu_b),
        .fu_sel (fu_sel),
        .fu_out (fu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit function unit.
    function automatic logic fu_bit(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'b000:  return ~a;
            3'b001:  return ~(a | b);
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a ^ b);
            default: return ~(a & b);
        endcase
    endfunction

    always_comb fu_out = fu_bit(fu_sel, fu_a, fu_b);

    // Whole-word reference: what the finished result must be.
    function automatic logic [WIDTH-1:0] ref_word(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            3'b000:  return ~a;
            3'b001:  return ~(a | b);
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a ^ b);
            default: return ~(a & b);
        endcase
    endfunction

    // One full operation with cycle-by-cycle checks. noise scrambles inputs after acceptance;
    // pulse_at >= 0 raises start with op=010 during that RUN cycle only.
    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit noise, input int pulse_at, input string nm);
        logic [WIDTH-1:0] exp;
        exp = ref_word(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise) begin
            op = 3'($urandom); opa = WIDTH'($urandom); opb = WIDTH'($urandom);
        end
        for (int c = 0; c < int'(WIDTH); c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", nm, c, busy, done);
            end
            checks++;
            if (fu_sel !== o) begin
                errors++;
                $display("FAIL %s run%0d fu_sel: got %b want %b", nm, c, fu_sel, o);
            end
            checks++;
            if (fu_a !== a[c] || fu_b !== b[c]) begin
                errors++;
                $display("FAIL %s run%0d fu_a/fu_b: got %b/%b want %b/%b", nm, c, fu_a, fu_b,
                         a[c], b[c]);
            end
            checks++;
            if (result !== last_result) begin
                errors++;
                $display("FAIL %s run%0d result held: got %h want %h", nm, c, result, last_result);
            end
            if (noise) begin
                start = 1'($urandom); op = 3'($urandom);
                opa = WIDTH'($urandom); opb = WIDTH'($urandom);
            end else if (c == pulse_at) begin
                start = 1'b1; op = 3'b010;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle busy/done: got %b/%b want 0/1", nm, busy, done);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", nm, result, exp);
        end
        checks++;
        if (fu_a !== 1'b0 || fu_b !== 1'b0 || fu_sel !== 3'b000) begin
            errors++;
            $display("FAIL %s done fu quiet: got %b %b %b want 0 0 000", nm, fu_a, fu_b, fu_sel);
        end
        last_result = exp;
        if (noise) start = 1'($urandom);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s idle after done: got busy %b done %b result %h want 0 0 %h", nm,
                     busy, done, result, exp);
        end
        checks++;
        if (fu_a !== 1'b0 || fu_b !== 1'b0 || fu_sel !== 3'b000) begin
            errors++;
            $display("FAIL %s idle fu quiet: got %b %b %b want 0 0 000", nm, fu_a, fu_b, fu_sel);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1; op = 3'b011; opa = 8'hFF; opb = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || fu_a !== 1'b0 || fu_b !== 1'b0 ||
            fu_sel !== 3'b000) begin
            errors++;
            $display("FAIL reset outputs: got busy %b done %b result %h fu %b%b%b want all 0",
                     busy, done, result, fu_a, fu_b, fu_sel);
        end
        start = 1'b0;
        last_result = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First rising edge after release must accept.
        run_op(3'b010, 8'hF0, 8'h3C, 1'b0, -1, "and_first_edge");
    endtask

    task automatic test_xor_stream();
        run_op(3'b100, 8'hA5, 8'hFF, 1'b0, -1, "xor_a5");
    endtask

    task automatic test_misc_ops();
        run_op(3'b000, 8'h0F, 8'h00, 1'b0, -1, "not_0f");
        run_op(3'b111, 8'hFF, 8'h0F, 1'b0, -1, "nand111");
        run_op(3'b101, 8'h33, 8'h0F, 1'b0, -1, "xnor");
        run_op(3'b110, 8'hC3, 8'h5A, 1'b0, -1, "nand110");
    endtask

    task automatic test_start_ignored();
        run_op(3'b011, 8'h01, 8'h80, 1'b0, 3, "or_ignore_start");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start = 1'b1; op = 3'b011; opa = 8'h01; opb = 8'h80;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || fu_a !== 1'b0 || fu_b !== 1'b0 ||
            fu_sel !== 3'b000) begin
            errors++;
            $display("FAIL abort async clear: got busy %b done %b result %h fu %b%b%b want all 0",
                     busy, done, result, fu_a, fu_b, fu_sel);
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== '0) begin
                errors++;
                $display("FAIL abort held: got done %b result %h want 0 00", done, result);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_result = '0;
        run_op(3'b001, 8'h0F, 8'h30, 1'b0, -1, "nor_after_abort");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_res;
        @(negedge clk);
        start = 1'b1; op = 3'b010; opa = 8'h12; opb = 8'hFF;
        @(posedge clk);
        #1;
        // Operand change after acceptance feeds only the next operation.
        opa = 8'h34;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            if (n < 8) exp_res = last_result;
            else if (n < 18) exp_res = 8'h12;
            else exp_res = 8'h34;
            checks++;
            if (done !== (n == 8 || n == 18)) begin
                errors++;
                $display("FAIL b2b done n%0d: got %b want %b", n, done, (n == 8 || n == 18));
            end
            checks++;
            if (busy !== ((n % 10) < 8)) begin
                errors++;
                $display("FAIL b2b busy n%0d: got %b want %b", n, busy, ((n % 10) < 8));
            end
            checks++;
            if (result !== exp_res) begin
                errors++;
                $display("FAIL b2b result n%0d: got %h want %h", n, result, exp_res);
            end
            if ((n % 10) >= 8) begin
                checks++;
                if (fu_a !== 1'b0 || fu_b !== 1'b0 || fu_sel !== 3'b000) begin
                    errors++;
                    $display("FAIL b2b fu quiet n%0d: got %b %b %b want 0 0 000", n, fu_a, fu_b,
                             fu_sel);
                end
            end
        end
        start = 1'b0;
        last_result = 8'h34;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b1, -1, "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_result = '0;
        rst_n = 1'b0;
        start = 1'b0;
        op = '0;
        opa = '0;
        opb = '0;
        test_reset();
        test_xor_stream();
        test_misc_ops();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
